ksm_irq_ctl: RTL and testbench

KSM_IRQ_CTL -- requirements
Module: ksm_irq_ctl

---
 rtl/ksm_irq_ctl.sv | 121 ++++++++++++
 tb/tb_ksm_irq_ctl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ksm_irq_ctl.sv
// ksm_irq_ctl: single-source vectored interrupt controller slave.
// Wishbone CSR/vector register, synchronised device-ready event,
// and a three-state request FSM towards the vectored interrupt controller.
// Optional build macro: KSM_IRQ_VECREG_EN (writable vector register at adr 1).
module ksm_irq_ctl #(
  parameter logic [15:0] VEC  = 16'o000060,
  parameter int          SYNC = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  input  logic        ev_i,
  output logic        ireq,
  input  logic        iack,
  output logic [15:0] ivec
);

  typedef enum logic [1:0] {IDLE, REQ, WAITCLR} state_t;

  state_t            state, state_nxt;
  logic [SYNC-1:0]   ev_sync;
  logic              ev_prev, ev_evt;
  logic              ie, done, err;
  logic              irq, irq_prev;
  logic              ack_set, wr_csr, clr_done_wr, clr_err_wr;
  logic [15:0]       csr, vec_val, rd_data;
  logic              unused_ok;

  assign ack_set     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr_csr      = ack_set & wb_we_i & ~wb_adr_i;
  assign clr_done_wr = wr_csr & ~wb_dat_i[7];
  assign clr_err_wr  = wr_csr & ~wb_dat_i[15];
  assign ev_evt      = ev_sync[SYNC-1] & ~ev_prev;
  assign irq         = ie & done;
  assign csr         = {err, 7'b0, done, ie, 6'b0};
  assign rd_data     = wb_adr_i ? vec_val : csr;
  assign ivec        = vec_val;
  // Data bits that no register stores are intentionally dropped.
  assign unused_ok   = &{1'b0, wb_dat_i};

`ifdef KSM_IRQ_VECREG_EN
  logic [15:0] vec_q;
  // Vector register: bits 1:0 always zero so the vector stays word aligned.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)                        vec_q <= VEC;
    else if (ack_set && wb_we_i && wb_adr_i) vec_q <= {wb_dat_i[15:2], 2'b00};
  end
  assign vec_val = vec_q;
`else
  assign vec_val = VEC;
`endif

  // Bus handshake: one ack clock per access, read data captured with it.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= 16'h0;
    end else begin
      wb_ack_o <= ack_set;
      if (ack_set && !wb_we_i) wb_dat_o <= rd_data;
    end
  end

  // Synchroniser and rising-edge detector on the asynchronous ready level.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ev_sync <= '0;
      ev_prev <= 1'b0;
    end else begin
      ev_sync <= {ev_sync[SYNC-2:0], ev_i};
      ev_prev <= ev_sync[SYNC-1];
    end
  end

  // Status flags; an event beats a same-clock DONE clear and leaves ERR alone.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ie   <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;
    end else begin
      if (wr_csr) ie <= wb_dat_i[6];
      if (ev_evt)           done <= 1'b1;
      else if (clr_done_wr) done <= 1'b0;
      if (ev_evt && done && !clr_done_wr)         err <= 1'b1;
      else if (clr_err_wr && !(ev_evt && clr_done_wr)) err <= 1'b0;
    end
  end

  // Request FSM state register; ireq is a flop decoded from the next state.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      irq_prev <= 1'b0;
      ireq     <= 1'b0;
    end else begin
      state    <= state_nxt;
      irq_prev <= irq;
      ireq     <= (state_nxt == REQ);
    end
  end

  // Next state: one request per IE&DONE rise, iack wins over a software clear.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (irq && !irq_prev) state_nxt = REQ;
      REQ:     if (iack)             state_nxt = WAITCLR;
               else if (!irq)        state_nxt = IDLE;
      WAITCLR: if (!irq)             state_nxt = IDLE;
      default:                       state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ksm_irq_ctl.sv
// Self-checking bench for ksm_irq_ctl: CSR vector table plus corner sequences.
// Reads are scoreboarded: expected data is queued when the read is issued and
// compared when the DUT acks.
module tb_ksm_irq_ctl;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wb_adr_i = 1'b0;
  logic [15:0] wb_dat_i = 16'h0;
  logic [15:0] wb_dat_o;
  logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic        wb_ack_o;
  logic        ev_i = 1'b0;
  logic        ireq;
  logic        iack = 1'b0;
  logic [15:0] ivec;

  int n_chk = 0;
  int n_err = 0;

  typedef struct { logic [15:0] exp; string nm; } sb_t;
  sb_t sb[$];

  typedef struct {
    int          nev;
    logic [15:0] wr;
    logic [15:0] csr;
    logic        irq;
  } vec_t;
  vec_t tbl[8];

  ksm_irq_ctl dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_cyc_i(wb_cyc_i),
    .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
    .ev_i(ev_i), .ireq(ireq), .iack(iack), .ivec(ivec)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %06o expected %06o", nm, act, exp);
    end
  endtask

  // Read monitor: pop the scoreboard on every read ack.
  always @(negedge wb_clk_i) begin
    if (wb_ack_o === 1'b1 && wb_we_i === 1'b0) begin
      if (sb.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL rd_unexpected: got %06o expected no read", wb_dat_o);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk(e.nm, wb_dat_o, e.exp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b1;
    tick(2);
    wb_rst_i = 1'b0;
    tick(1);
  endtask

  task automatic bus_wr(input logic adr, input logic [15:0] d);
    wb_adr_i = adr; wb_dat_i = d; wb_we_i = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    tick(1);
    chk("wr_ack", {15'b0, wb_ack_o}, 16'd1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    tick(1);
    wb_we_i = 1'b0;
  endtask

  task automatic bus_rd(input logic adr, input logic [15:0] exp, input string nm);
    sb_t e;
    e.exp = exp; e.nm = nm;
    sb.push_back(e);
    wb_adr_i = adr; wb_we_i = 1'b0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    tick(1);
    chk("rd_ack", {15'b0, wb_ack_o}, 16'd1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    tick(1);
  endtask

  task automatic pulse_ev();
    ev_i = 1'b1;
    tick(4);
    ev_i = 1'b0;
    tick(3);
  endtask

  initial begin
    tbl[0] = '{0, 16'o000100, 16'o000100, 1'b0};
    tbl[1] = '{1, 16'o000100, 16'o000100, 1'b0};
    tbl[2] = '{1, 16'o000300, 16'o000300, 1'b1};
    tbl[3] = '{2, 16'o100300, 16'o100300, 1'b1};
    tbl[4] = '{2, 16'o100100, 16'o100100, 1'b0};
    tbl[5] = '{2, 16'o000000, 16'o000000, 1'b0};
    tbl[6] = '{2, 16'o000200, 16'o000200, 1'b0};
    tbl[7] = '{1, 16'o177777, 16'o000300, 1'b1};

    // Reset state
    #1;
    chk("rst_ack", {15'b0, wb_ack_o}, 16'd0);
    chk("rst_dat", wb_dat_o, 16'h0);
    chk("rst_ireq", {15'b0, ireq}, 16'd0);
    chk("rst_ivec", ivec, 16'o000060);
    do_reset();
    bus_rd(1'b0, 16'o000000, "rst_csr");
    bus_rd(1'b1, 16'o000060, "rst_vec");

    // CSR behaviour table
    for (int i = 0; i < 8; i++) begin
      do_reset();
      for (int k = 0; k < tbl[i].nev; k++) pulse_ev();
      bus_wr(1'b0, tbl[i].wr);
      tick(2);
      bus_rd(1'b0, tbl[i].csr, $sformatf("tbl%0d_csr", i));
      chk($sformatf("tbl%0d_ireq", i), {15'b0, ireq}, {15'b0, tbl[i].irq});
    end

    // Event timing, iack handshake, iack ignored outside REQ
    do_reset();
    bus_wr(1'b0, 16'o000100);
    ev_i = 1'b1;
    tick(3);
    chk("seq1_ireq_early", {15'b0, ireq}, 16'd0);
    tick(1);
    chk("seq1_ireq_rise", {15'b0, ireq}, 16'd1);
    tick(3);
    chk("seq1_ireq_hold", {15'b0, ireq}, 16'd1);
    iack = 1'b1; tick(1); iack = 1'b0;
    chk("seq1_ireq_ack", {15'b0, ireq}, 16'd0);
    iack = 1'b1; tick(1); iack = 1'b0; tick(2);
    chk("seq1_iack_waitclr", {15'b0, ireq}, 16'd0);
    bus_rd(1'b0, 16'o000300, "seq1_csr");
    ev_i = 1'b0; tick(3);

    // IE set while DONE already 1, then software clear in REQ
    do_reset();
    pulse_ev();
    chk("seq2_ireq_ie0", {15'b0, ireq}, 16'd0);
    bus_wr(1'b0, 16'o000300);
    chk("seq2_ireq_rise", {15'b0, ireq}, 16'd1);
    bus_wr(1'b0, 16'o000000);
    chk("seq2_ireq_swclr", {15'b0, ireq}, 16'd0);
    tick(2);
    chk("seq2_ireq_stay", {15'b0, ireq}, 16'd0);
    bus_rd(1'b0, 16'o000000, "seq2_csr");

    // Event lands on the same clock as a DONE-clearing write
    do_reset();
    ev_i = 1'b1;
    tick(2);
    bus_wr(1'b0, 16'o000100);
    chk("seq3_ireq", {15'b0, ireq}, 16'd1);
    bus_rd(1'b0, 16'o000300, "seq3_csr");
    ev_i = 1'b0; tick(3);

    // Vector register
    do_reset();
    bus_wr(1'b1, 16'o000127);
`ifdef KSM_IRQ_VECREG_EN
    chk("vec_ivec", ivec, 16'o000124);
    bus_rd(1'b1, 16'o000124, "vec_rd");
`else
    chk("vec_ivec", ivec, 16'o000060);
    bus_rd(1'b1, 16'o000060, "vec_rd");
`endif

    // Asynchronous reset mid-request, ev_i held high across it
    do_reset();
    bus_wr(1'b0, 16'o000100);
    ev_i = 1'b1;
    tick(4);
    chk("seq4_ireq_pre", {15'b0, ireq}, 16'd1);
    wb_rst_i = 1'b1;
    #1;
    chk("seq4_ireq_async", {15'b0, ireq}, 16'd0);
    tick(1);
    wb_rst_i = 1'b0;
    tick(5);
    bus_rd(1'b0, 16'o000200, "seq4_csr_one_evt");
    bus_wr(1'b0, 16'o000000);
    tick(5);
    bus_rd(1'b0, 16'o000000, "seq4_csr_no_more");
    ev_i = 1'b0;
    tick(3);

    chk("sb_drain", 16'(sb.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Watchdog: the sequence is fixed-length, so this only fires on a hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
